cpu_memory: RTL and testbench
=============================

CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 SHALL have parameter TIMEOUT: default 0; bus wait-cycle limit, 0 = no limit.
REQ-002 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have these control and execute-result inputs:
- i_stall  in  1  downstream (writeback) stall.
- i_tag  in  TAG_SIZE  execute result tag.
- i_inst_rd  in  5  destination register.
- i_rd  in  32  execute result.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_mem_width  in  3  access width.
- i_mem_signed  in  1  sign-extend loads.
- i_mem_address  in  32  byte address.
- i_mem_wdata  in  32  store data (rs2).
REQ-004 SHALL have these bus ports:
- o_bus_request  out  1  bus access active.
- o_bus_rw  out  1  1 = write.
- o_bus_address  out  32  word-aligned address.
- o_bus_wdata  out  32  lane-shifted store data.
- o_bus_wmask  out  4  byte enables.
- i_bus_ready  in  1  access complete.
- i_bus_rdata  in  32  read word.
REQ-005 SHALL have these result ports:
- o_tag  out  TAG_SIZE  completed tag.
- o_inst_rd  out  5  destination register.
- o_rd  out  32  result.
- o_fault  out  1  misaligned access or timeout.
- o_stall  out  1  stage busy, toward execute.

Function
REQ-006 SHALL accept a new request when !i_stall && (i_tag != o_tag), and only in state IDLE.
REQ-007 SHALL use states IDLE, READ_WAIT and WRITE_WAIT:
- IDLE -> READ_WAIT on an accepted load.
- IDLE -> WRITE_WAIT on an accepted store.
- READ_WAIT or WRITE_WAIT -> IDLE on i_bus_ready or on timeout.
REQ-008 SHALL complete a non-memory request in 1 cycle: o_tag <= i_tag, o_inst_rd <= i_inst_rd, o_rd <= i_rd, state stays IDLE.
REQ-009 SHALL drive the bus as follows: o_bus_address = {addr[31:2],2'b00}; o_bus_request held high from the entry clock edge until the cycle where i_bus_ready=1; bus outputs held stable throughout.
REQ-010 SHALL generate store masks and data by width:
- Byte: wmask = 1<<addr[1:0], wdata = data[7:0] replicated on all lanes.
- Half: wmask = 4'b0011<<addr[1:0], wdata = data[15:0] replicated.
- Word: wmask = 4'b1111, wdata = i_mem_wdata.
REQ-011 SHALL extract loads from rdata at lane addr[1:0] and sign- or zero-extend to 32 bits per i_mem_signed; word loads are not extended.
REQ-012 SHALL, in the cycle i_bus_ready=1, register o_rd with the load result (store: o_rd unchanged), set o_tag <= latched tag, and return to IDLE; minimum load/store latency is 2 cycles.
REQ-013 SHALL treat half access with addr[0]=1 or word access with addr[1:0]!=0 as misaligned:
- no bus request issued;
- complete in 1 cycle with o_fault=1, o_rd=0.
REQ-014 SHALL, when TIMEOUT>0, count wait cycles; when the count reaches TIMEOUT:
- drop o_bus_request;
- set o_fault=1;
- complete the tag.
REQ-015 SHALL clear o_fault on the next accepted request.
REQ-016 SHALL assert o_stall = (state != IDLE) || (request && access); execute holds its outputs while o_stall=1.
REQ-017 SHALL ignore i_stall rising mid-access: the bus access completes; the result is held, and no new request is accepted until i_stall=0.
REQ-018 SHALL ignore i_bus_ready while IDLE.

Reset
REQ-019 SHALL, on i_reset low, asynchronously force state IDLE and all outputs to 0, including o_tag=0, o_bus_request=0 and the timeout counter.
REQ-020 SHALL abandon an in-flight access on reset mid-operation: request deasserted and the tag not completed.

Structure
REQ-021 SHALL take TAG_SIZE, MEM_WIDTH_BYTE=3'd1, MEM_WIDTH_HALF=3'd2 and MEM_WIDTH_WORD=3'd4 from the shared CPU defines file.
REQ-022 SHALL place the state encodings in the shared CPU defines file.
REQ-023 SHALL implement lane alignment (load extract/extend, store mask/shift) as combinational sub-module cpu_memory_align.

Verification
REQ-024 SHALL cover load byte, signed: addr=0x1003, rdata=0x80FFFFFF, ready after 2 cycles -> o_rd=0xFFFFFF80, tag updated, o_fault=0.
REQ-025 SHALL cover store half: addr=0x2002, data=0x1234ABCD -> o_bus_wmask=4'b1100, o_bus_wdata=0xABCDABCD, o_bus_address=0x2000.
REQ-026 SHALL cover a non-memory request: tag change, rd=0x55 -> o_rd=0x55 next cycle, o_bus_request never high.
REQ-027 SHALL cover a misaligned word load at 0x1001 -> o_fault=1 in 1 cycle, no bus request.
REQ-028 SHALL cover TIMEOUT=4 with i_bus_ready held 0 -> request dropped after 4 wait cycles, o_fault=1, tag completed.
REQ-029 SHALL cover i_reset low during READ_WAIT -> o_bus_request=0 immediately, o_tag=0, state IDLE.

Source files
------------

// File: rtl/cpu_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory_pkg
// Purpose  : Shared CPU defines for the memory stage (tag size, access widths,
//            memory-stage state encodings).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_memory_pkg;

    localparam int TAG_SIZE = 8;

    localparam logic [2:0] MEM_WIDTH_BYTE = 3'd1;
    localparam logic [2:0] MEM_WIDTH_HALF = 3'd2;
    localparam logic [2:0] MEM_WIDTH_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_memory_align.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory_align
// Purpose  : Combinational byte-lane alignment: store mask/replication, load
//            extraction/extension and misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_memory_align
    import cpu_memory_pkg::*;
(
    input  logic [2:0]  i_width,
    input  logic        i_signed,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    // Any width code other than byte/half behaves as a full word.
    always_comb begin
        o_wmask      = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = (i_offset != 2'b00);
        case (i_width)
            MEM_WIDTH_BYTE: begin
                o_wmask      = 4'b0001 << i_offset;
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = {{24{i_signed & w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            MEM_WIDTH_HALF: begin
                o_wmask      = 4'b0011 << i_offset;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{i_signed & w_half[15]}}, w_half};
                o_misaligned = i_offset[0];
            end
            default: begin
                o_wmask      = 4'b1111;
                o_wdata      = i_wdata;
                o_rdata      = i_rdata;
                o_misaligned = (i_offset != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_memory.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory
// Purpose  : CPU memory stage: issues aligned bus loads/stores, passes
//            non-memory results through, flags misalignment and bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic [TAG_SIZE-1:0] i_tag,
    input  logic [4:0]          i_inst_rd,
    input  logic [31:0]         i_rd,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_mem_width,
    input  logic                i_mem_signed,
    input  logic [31:0]         i_mem_address,
    input  logic [31:0]         i_mem_wdata,
    output logic                o_bus_request,
    output logic                o_bus_rw,
    output logic [31:0]         o_bus_address,
    output logic [31:0]         o_bus_wdata,
    output logic [3:0]          o_bus_wmask,
    input  logic                i_bus_ready,
    input  logic [31:0]         i_bus_rdata,
    output logic [TAG_SIZE-1:0] o_tag,
    output logic [4:0]          o_inst_rd,
    output logic [31:0]         o_rd,
    output logic                o_fault,
    output logic                o_stall
);

    localparam logic [31:0] c_timeout_last = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    mem_state_t          state_q, state_d;
    logic                req_q, req_d;
    logic                rw_q, rw_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [TAG_SIZE-1:0] tag_q, tag_d;
    logic [4:0]          inst_rd_q, inst_rd_d;
    logic [31:0]         rd_q, rd_d;
    logic                fault_q, fault_d;
    logic [TAG_SIZE-1:0] pend_tag_q, pend_tag_d;
    logic [4:0]          pend_rd_q, pend_rd_d;
    logic [2:0]          width_q, width_d;
    logic                signed_q, signed_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         cnt_q, cnt_d;

    logic        w_request;
    logic        w_access;
    logic        w_accept;
    logic        w_timeout;
    logic [2:0]  w_width;
    logic        w_signed;
    logic [1:0]  w_offset;
    logic [3:0]  w_al_wmask;
    logic [31:0] w_al_wdata;
    logic [31:0] w_al_rdata;
    logic        w_al_misaligned;

    assign w_request = (i_tag != tag_q);
    assign w_access  = i_mem_read | i_mem_write;
    assign w_accept  = (state_q == ST_IDLE) && !i_stall && w_request;
    assign w_timeout = (TIMEOUT != 0) && (cnt_q == c_timeout_last);

    // Alignment sees the live request while idle and the latched access while waiting.
    assign w_width  = (state_q == ST_IDLE) ? i_mem_width        : width_q;
    assign w_signed = (state_q == ST_IDLE) ? i_mem_signed       : signed_q;
    assign w_offset = (state_q == ST_IDLE) ? i_mem_address[1:0] : off_q;

    cpu_memory_align u_align (
        .i_width      (w_width),
        .i_signed     (w_signed),
        .i_offset     (w_offset),
        .i_wdata      (i_mem_wdata),
        .i_rdata      (i_bus_rdata),
        .o_wmask      (w_al_wmask),
        .o_wdata      (w_al_wdata),
        .o_rdata      (w_al_rdata),
        .o_misaligned (w_al_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        tag_d      = tag_q;
        inst_rd_d  = inst_rd_q;
        rd_d       = rd_q;
        fault_d    = fault_q;
        pend_tag_d = pend_tag_q;
        pend_rd_d  = pend_rd_q;
        width_d    = width_q;
        signed_d   = signed_q;
        off_d      = off_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    fault_d = 1'b0;
                    if (!w_access) begin
                        tag_d     = i_tag;
                        inst_rd_d = i_inst_rd;
                        rd_d      = i_rd;
                    end else if (w_al_misaligned) begin
                        tag_d     = i_tag;
                        inst_rd_d = i_inst_rd;
                        rd_d      = 32'd0;
                        fault_d   = 1'b1;
                    end else begin
                        pend_tag_d = i_tag;
                        pend_rd_d  = i_inst_rd;
                        width_d    = i_mem_width;
                        signed_d   = i_mem_signed;
                        off_d      = i_mem_address[1:0];
                        cnt_d      = 32'd0;
                        req_d      = 1'b1;
                        addr_d     = {i_mem_address[31:2], 2'b00};
                        if (i_mem_read) begin
                            rw_d    = 1'b0;
                            wmask_d = 4'b0000;
                            wdata_d = 32'd0;
                            state_d = ST_READ_WAIT;
                        end else begin
                            rw_d    = 1'b1;
                            wmask_d = w_al_wmask;
                            wdata_d = w_al_wdata;
                            state_d = ST_WRITE_WAIT;
                        end
                    end
                end
            end
            ST_READ_WAIT, ST_WRITE_WAIT: begin
                if (i_bus_ready || w_timeout) begin
                    req_d     = 1'b0;
                    rw_d      = 1'b0;
                    addr_d    = 32'd0;
                    wdata_d   = 32'd0;
                    wmask_d   = 4'b0000;
                    tag_d     = pend_tag_q;
                    inst_rd_d = pend_rd_q;
                    cnt_d     = 32'd0;
                    state_d   = ST_IDLE;
                    // A bus ready arriving in the timeout cycle still wins.
                    if (i_bus_ready) begin
                        if (state_q == ST_READ_WAIT) begin
                            rd_d = w_al_rdata;
                        end
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'b0000;
            tag_q      <= '0;
            inst_rd_q  <= 5'd0;
            rd_q       <= 32'd0;
            fault_q    <= 1'b0;
            pend_tag_q <= '0;
            pend_rd_q  <= 5'd0;
            width_q    <= 3'd0;
            signed_q   <= 1'b0;
            off_q      <= 2'd0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            tag_q      <= tag_d;
            inst_rd_q  <= inst_rd_d;
            rd_q       <= rd_d;
            fault_q    <= fault_d;
            pend_tag_q <= pend_tag_d;
            pend_rd_q  <= pend_rd_d;
            width_q    <= width_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_bus_request = req_q;
    assign o_bus_rw      = rw_q;
    assign o_bus_address = addr_q;
    assign o_bus_wdata   = wdata_q;
    assign o_bus_wmask   = wmask_q;
    assign o_tag         = tag_q;
    assign o_inst_rd     = inst_rd_q;
    assign o_rd          = rd_q;
    assign o_fault       = fault_q;
    // Held low while in reset so every output reads zero.
    assign o_stall       = i_reset && ((state_q != ST_IDLE) || (w_request && w_access));

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_memory
// Purpose  : Self-checking bench for cpu_memory against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_memory;
    import cpu_memory_pkg::*;

    localparam int TO = 4;

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_stall = 1'b0;
    logic [TAG_SIZE-1:0] i_tag = '0;
    logic [4:0]          i_inst_rd = '0;
    logic [31:0]         i_rd = '0;
    logic                i_mem_read = 1'b0;
    logic                i_mem_write = 1'b0;
    logic [2:0]          i_mem_width = '0;
    logic                i_mem_signed = 1'b0;
    logic [31:0]         i_mem_address = '0;
    logic [31:0]         i_mem_wdata = '0;
    logic                i_bus_ready = 1'b0;
    logic [31:0]         i_bus_rdata = '0;
    logic                o_bus_request;
    logic                o_bus_rw;
    logic [31:0]         o_bus_address;
    logic [31:0]         o_bus_wdata;
    logic [3:0]          o_bus_wmask;
    logic [TAG_SIZE-1:0] o_tag;
    logic [4:0]          o_inst_rd;
    logic [31:0]         o_rd;
    logic                o_fault;
    logic                o_stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [TAG_SIZE-1:0] m_tag = '0;
    logic [31:0]         m_rd = '0;

    cpu_memory #(.TIMEOUT(TO)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_stall       (i_stall),
        .i_tag         (i_tag),
        .i_inst_rd     (i_inst_rd),
        .i_rd          (i_rd),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_mem_width   (i_mem_width),
        .i_mem_signed  (i_mem_signed),
        .i_mem_address (i_mem_address),
        .i_mem_wdata   (i_mem_wdata),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .o_bus_wmask   (o_bus_wmask),
        .i_bus_ready   (i_bus_ready),
        .i_bus_rdata   (i_bus_rdata),
        .o_tag         (o_tag),
        .o_inst_rd     (o_inst_rd),
        .o_rd          (o_rd),
        .o_fault       (o_fault),
        .o_stall       (o_stall)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] w, input bit sg,
                                             input int off, input logic [31:0] data);
        int unsigned v;
        v = data >> (8 * off);
        if (w == MEM_WIDTH_BYTE) begin
            v = v % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (w == MEM_WIDTH_HALF) begin
            v = v % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wmask(input logic [2:0] w, input int off);
        if (w == MEM_WIDTH_BYTE) return 32'(1 << off);
        if (w == MEM_WIDTH_HALF) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] w, input logic [31:0] d);
        if (w == MEM_WIDTH_BYTE) return (d % 256) * 32'h0101_0101;
        if (w == MEM_WIDTH_HALF) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] w, input int off);
        if (w == MEM_WIDTH_HALF) return (off % 2) != 0;
        if (w == MEM_WIDTH_WORD) return off != 0;
        return 1'b0;
    endfunction

    // Called at posedge+1 with the DUT idle; delay = wait cycles before ready.
    task automatic run_txn(input logic [TAG_SIZE-1:0] tag, input logic [4:0] ird,
                           input logic [31:0] rdv, input bit ld, input bit st,
                           input logic [2:0] w, input bit sg, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int delay, input bit stall_first, input bit stall_mid);
        bit access;
        bit mis;
        int off;
        off    = int'(a % 4);
        access = ld || st;
        mis    = access && ref_misaligned(w, off);

        i_tag = tag; i_inst_rd = ird; i_rd = rdv;
        i_mem_read = ld; i_mem_write = st; i_mem_width = w; i_mem_signed = sg;
        i_mem_address = a; i_mem_wdata = wd;
        i_stall = stall_first;
        i_bus_ready = 1'($urandom % 2);
        i_bus_rdata = $urandom;
        #1;
        check_eq("stall_on_request", 32'(o_stall), 32'(access));

        if (stall_first) begin
            @(posedge i_clock); #1;
            check_eq("held_tag", 32'(o_tag), 32'(m_tag));
            check_eq("held_req", 32'(o_bus_request), 32'd0);
            i_stall = 1'b0;
        end

        @(posedge i_clock); #1;
        i_bus_ready = 1'b0;

        if (!access) begin
            check_eq("pass_tag", 32'(o_tag), 32'(tag));
            check_eq("pass_rd", o_rd, rdv);
            check_eq("pass_inst_rd", 32'(o_inst_rd), 32'(ird));
            check_eq("pass_fault", 32'(o_fault), 32'd0);
            check_eq("pass_no_req", 32'(o_bus_request), 32'd0);
            m_rd = rdv;
            m_tag = tag;
        end else if (mis) begin
            check_eq("mis_tag", 32'(o_tag), 32'(tag));
            check_eq("mis_rd", o_rd, 32'd0);
            check_eq("mis_fault", 32'(o_fault), 32'd1);
            check_eq("mis_no_req", 32'(o_bus_request), 32'd0);
            m_rd = 32'd0;
            m_tag = tag;
        end else begin
            check_eq("bus_req", 32'(o_bus_request), 32'd1);
            check_eq("bus_rw", 32'(o_bus_rw), 32'(!ld));
            check_eq("bus_addr", o_bus_address, a - 32'(off));
            if (!ld) begin
                check_eq("bus_wmask", 32'(o_bus_wmask), ref_wmask(w, off));
                check_eq("bus_wdata", o_bus_wdata, ref_wdata(w, wd));
            end
            for (int k = 0; k < 16; k++) begin
                check_eq("wait_stall", 32'(o_stall), 32'd1);
                i_stall = stall_mid ? 1'($urandom % 2) : 1'b0;
                i_bus_ready = (k == delay);
                i_bus_rdata = (k == delay) ? rdata : $urandom;
                @(posedge i_clock); #1;
                if (k == delay) begin
                    check_eq("done_req", 32'(o_bus_request), 32'd0);
                    check_eq("done_tag", 32'(o_tag), 32'(tag));
                    check_eq("done_fault", 32'(o_fault), 32'd0);
                    if (ld) begin
                        m_rd = ref_load(w, sg, off, rdata);
                        check_eq("load_inst_rd", 32'(o_inst_rd), 32'(ird));
                    end
                    check_eq("done_rd", o_rd, m_rd);
                    break;
                end
                if (k == TO - 1) begin
                    check_eq("to_req", 32'(o_bus_request), 32'd0);
                    check_eq("to_fault", 32'(o_fault), 32'd1);
                    check_eq("to_tag", 32'(o_tag), 32'(tag));
                    break;
                end
                check_eq("wait_req", 32'(o_bus_request), 32'd1);
                check_eq("wait_addr", o_bus_address, a - 32'(off));
                if (k == 15) check_eq("wait_bound", 32'd0, 32'd1);
            end
            m_tag = tag;
            i_bus_ready = 1'b0;
            i_stall = 1'b0;
        end
        i_mem_read = 1'b0;
        i_mem_write = 1'b0;
    endtask

    initial begin
        logic [2:0] widths [3];
        widths[0] = MEM_WIDTH_BYTE;
        widths[1] = MEM_WIDTH_HALF;
        widths[2] = MEM_WIDTH_WORD;

        i_tag = 8'h11;
        #1;
        check_eq("rst_tag", 32'(o_tag), 32'd0);
        check_eq("rst_req", 32'(o_bus_request), 32'd0);
        check_eq("rst_rd", o_rd, 32'd0);
        check_eq("rst_fault", 32'(o_fault), 32'd0);
        check_eq("rst_stall", 32'(o_stall), 32'd0);
        i_tag = '0;
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b1;

        run_txn(8'd1, 5'd3, 32'h55, 0, 0, MEM_WIDTH_WORD, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_txn(8'd2, 5'd4, 32'h0, 1, 0, MEM_WIDTH_BYTE, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 1, 0, 0);
        run_txn(8'd3, 5'd5, 32'h0, 0, 1, MEM_WIDTH_HALF, 0, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        run_txn(8'd4, 5'd6, 32'h0, 1, 0, MEM_WIDTH_WORD, 0, 32'h1001, 32'h0, 32'h0, 0, 0, 0);
        run_txn(8'd5, 5'd7, 32'h0, 1, 0, MEM_WIDTH_WORD, 0, 32'h3000, 32'h0, 32'h0, 10, 0, 0);
        run_txn(8'd6, 5'd8, 32'h77, 0, 0, MEM_WIDTH_WORD, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("fault_cleared", 32'(o_fault), 32'd0);

        // Reset in the middle of a read wait abandons the access.
        i_tag = 8'd7; i_mem_read = 1'b1; i_mem_width = MEM_WIDTH_WORD; i_mem_address = 32'h4000;
        @(posedge i_clock); #1;
        check_eq("pre_rst_req", 32'(o_bus_request), 32'd1);
        i_reset = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(o_bus_request), 32'd0);
        check_eq("mid_rst_tag", 32'(o_tag), 32'd0);
        check_eq("mid_rst_stall", 32'(o_stall), 32'd0);
        i_tag = '0; i_mem_read = 1'b0;
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        i_bus_ready = 1'b1;
        @(posedge i_clock); #1;
        check_eq("post_rst_tag", 32'(o_tag), 32'd0);
        check_eq("post_rst_req", 32'(o_bus_request), 32'd0);
        i_bus_ready = 1'b0;
        m_tag = '0;
        m_rd = '0;

        for (int n = 0; n < 80; n++) begin
            logic [TAG_SIZE-1:0] t;
            int kind;
            int dly;
            t = m_tag + TAG_SIZE'(1 + $urandom % 3);
            kind = int'($urandom % 3);
            dly = ($urandom % 8 == 0) ? 5 : int'($urandom % 4);
            run_txn(t, 5'($urandom), $urandom, kind == 1, kind == 2,
                    widths[$urandom % 3], 1'($urandom % 2), $urandom, $urandom, $urandom,
                    dly, ($urandom % 5) == 0, ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
